decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_WIDTH, 12: program-counter width.
- WORD_WIDTH, 16: instruction width.
- OPCODE_WIDTH, 4: opcode field width, taken from the instruction MSBs.
- JMP_OPCODE, 'h9: absolute-jump opcode.
- REL_JMP_OPCODE, 'hA: relative-jump opcode (used only with DECODE_REL_JMP_EN).
- CNT_WIDTH, 16: width of the retired-instruction counter.
REQ-002 Derived widths:
- FULL_W = WORD_WIDTH-OPCODE_WIDTH.
- OP_W = FULL_W/2.
- FULL_W SHALL be even; an odd FULL_W is an elaboration error.
REQ-003 Ports (name, direction, width, meaning):
- i_clk, in, 1: single clock; all state updates on its rising edge.
- i_rst, in, 1: asynchronous, active-high reset.
- i_flush, in, 1: synchronous pipeline flush.
- i_valid, in, 1: upstream instruction valid.
- o_ready, out, 1: decode can accept an instruction.
- i_inst, in, WORD_WIDTH: instruction from fetch.
- i_pc, in, ADDR_WIDTH: PC of i_inst.
- o_valid, out, 1: decoded instruction valid.
- i_ready, in, 1: execute accepts the decoded instruction.
- o_opcode, out, OPCODE_WIDTH: inst[WORD_WIDTH-1 -: OPCODE_WIDTH].
- o_operand_full, out, FULL_W: inst[FULL_W-1:0].
- o_operand1, out, OP_W: upper half of o_operand_full.
- o_operand2, out, OP_W: lower half of o_operand_full.
- o_pc, out, ADDR_WIDTH: PC of the presented instruction.
- o_is_jmp, out, 1: the presented instruction is a jump.
- o_next_pc, out, ADDR_WIDTH: jump target.
- o_retired, out, CNT_WIDTH: count of instructions handed downstream.

Function
REQ-004 An upstream transfer SHALL occur when i_valid && o_ready; a downstream transfer SHALL occur when o_valid && i_ready.
REQ-005 Storage SHALL be an output register (OUT) plus one skid register (SKID), each holding {inst, pc, valid}.
REQ-006 o_ready SHALL equal !SKID.valid; it SHALL NOT depend combinationally on i_ready.
REQ-007 Latency: an instruction accepted into an empty stage SHALL appear on the outputs with o_valid=1 on the next cycle.
REQ-008 Accept while OUT is empty or draining SHALL load OUT; accept while OUT is holding (o_valid && !i_ready) SHALL load SKID.
REQ-009 On a downstream transfer with SKID valid, SKID SHALL move to OUT and SKID SHALL clear in the same cycle.
REQ-010 While o_valid && !i_ready, all decoded outputs SHALL remain stable.
REQ-011 Ordering SHALL be preserved; no instruction SHALL be dropped or duplicated except by flush.
REQ-012 i_flush SHALL clear OUT.valid and SKID.valid on the next edge and SHALL take priority over a simultaneous upstream accept (that input is discarded) and over a downstream transfer.
REQ-013 o_is_jmp SHALL be o_valid && (o_opcode == JMP_OPCODE).
REQ-014 For an absolute jump, o_next_pc SHALL be o_operand_full zero-extended or truncated to ADDR_WIDTH.
REQ-015 Decoded outputs SHALL be 0 whenever o_valid=0.
REQ-016 o_retired SHALL increment by 1 on each downstream transfer and wrap from 2^CNT_WIDTH-1 to 0; flushed instructions SHALL NOT be counted.

Reset
REQ-017 Asserting i_rst SHALL immediately clear OUT, SKID and o_retired; o_valid, o_is_jmp, o_next_pc and the decoded fields SHALL read 0, and o_ready SHALL read 1.
REQ-018 Reset mid-transfer SHALL discard both held instructions; the first accept after reset release behaves per REQ-007.

Configuration
REQ-019 With macro DECODE_REL_JMP_EN defined:
- o_is_jmp SHALL also assert for o_opcode == REL_JMP_OPCODE.
- o_next_pc SHALL then be o_pc + sign-extended o_operand_full, modulo 2^ADDR_WIDTH.
REQ-020 Without DECODE_REL_JMP_EN, REL_JMP_OPCODE SHALL decode as an ordinary non-jump instruction and no adder SHALL be synthesised.

Verification (defaults)
REQ-021 Accept i_inst='h9123, i_pc=5, i_ready=1 -> next cycle: o_valid=1, o_is_jmp=1, o_next_pc='h123, o_operand1='h04, o_operand2='h23.
REQ-022 Hold i_ready=0; send 'h1001 then 'h2002 -> o_ready=0 after the second accept and o_opcode=1 stable; raise i_ready -> 'h1001 then 'h2002 presented, o_retired=2.
REQ-023 i_flush with i_valid=1 and SKID full -> next cycle o_valid=0, o_ready=1, o_retired unchanged, flushed input never presented.
REQ-024 DECODE_REL_JMP_EN defined; i_inst='hAFFE at i_pc=10 -> o_is_jmp=1, o_next_pc=8. Same stimulus with the macro undefined -> o_is_jmp=0.
REQ-025 Assert i_rst asynchronously with OUT and SKID full -> o_valid=0, o_ready=1 and o_retired=0 before the next clock edge.
REQ-026 CNT_WIDTH=4; perform 17 downstream transfers -> o_retired=1.

Source files
------------

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_pipe
// Purpose  : Single-stage instruction decode with a valid/ready handshake on
//            both sides. Storage is an output register (OUT) plus one skid
//            register (SKID), so o_ready is a plain register output and never
//            depends combinationally on i_ready. It splits out the opcode and
//            operand fields, flags jumps, computes the jump target and counts
//            the instructions handed downstream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk          in   1             clock, rising edge
//   i_rst          in   1             asynchronous active-high reset
//   i_flush        in   1             synchronous flush of OUT and SKID
//   i_valid        in   1             upstream instruction valid
//   o_ready        out  1             decode can accept (SKID empty)
//   i_inst         in   WORD_WIDTH    instruction from fetch
//   i_pc           in   ADDR_WIDTH    PC of i_inst
//   o_valid        out  1             decoded instruction valid
//   i_ready        in   1             execute accepts decoded instruction
//   o_opcode       out  OPCODE_WIDTH  instruction MSBs
//   o_operand_full out  FULL_W        instruction bits below the opcode
//   o_operand1     out  OP_W          upper half of o_operand_full
//   o_operand2     out  OP_W          lower half of o_operand_full
//   o_pc           out  ADDR_WIDTH    PC of the presented instruction
//   o_is_jmp       out  1             presented instruction is a jump
//   o_next_pc      out  ADDR_WIDTH    jump target
//   o_retired      out  CNT_WIDTH     instructions handed downstream (wraps)
// ----------------------------------------------------------------------------
// Build option
//   DECODE_REL_JMP_EN : when defined, REL_JMP_OPCODE is also a jump whose
//                       target is o_pc + sign-extended o_operand_full.
// ============================================================================
module decode_pipe #(
    parameter int                       ADDR_WIDTH     = 12,
    parameter int                       WORD_WIDTH     = 16,
    parameter int                       OPCODE_WIDTH   = 4,
    parameter logic [OPCODE_WIDTH-1:0]  JMP_OPCODE     = 'h9,
    parameter logic [OPCODE_WIDTH-1:0]  REL_JMP_OPCODE = 'hA,
    parameter int                       CNT_WIDTH      = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_flush,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [WORD_WIDTH-1:0]             i_inst,
    input  logic [ADDR_WIDTH-1:0]             i_pc,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [OPCODE_WIDTH-1:0]           o_opcode,
    output logic [WORD_WIDTH-OPCODE_WIDTH-1:0] o_operand_full,
    output logic [(WORD_WIDTH-OPCODE_WIDTH)/2-1:0] o_operand1,
    output logic [(WORD_WIDTH-OPCODE_WIDTH)/2-1:0] o_operand2,
    output logic [ADDR_WIDTH-1:0]             o_pc,
    output logic                              o_is_jmp,
    output logic [ADDR_WIDTH-1:0]             o_next_pc,
    output logic [CNT_WIDTH-1:0]              o_retired
);

    localparam int FULL_W = WORD_WIDTH - OPCODE_WIDTH;
    localparam int OP_W   = FULL_W / 2;

    generate
        if ((FULL_W % 2) != 0) begin : g_bad_full_w
            $error("decode_pipe: WORD_WIDTH-OPCODE_WIDTH must be even");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] out_inst_q,  out_inst_d;
    logic [ADDR_WIDTH-1:0] out_pc_q,    out_pc_d;
    logic                  out_vld_q,   out_vld_d;
    logic [WORD_WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q,   skid_pc_d;
    logic                  skid_vld_q,  skid_vld_d;
    logic [CNT_WIDTH-1:0]  retired_q,   retired_d;

    logic w_up_xfer;
    logic w_dn_xfer;

    assign o_ready   = !skid_vld_q;
    assign w_up_xfer = i_valid && o_ready;
    assign w_dn_xfer = out_vld_q && i_ready;

    always_comb begin
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_vld_d   = out_vld_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_vld_d  = skid_vld_q;
        retired_d   = retired_q;

        if (i_flush) begin
            // Flush wins over both handshakes; nothing is counted.
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            if (w_dn_xfer) begin
                retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end

            if (w_dn_xfer || !out_vld_q) begin
                // OUT is free this cycle. A full SKID is older than anything
                // upstream (and blocks upstream via o_ready), so it goes first.
                if (skid_vld_q) begin
                    out_inst_d = skid_inst_q;
                    out_pc_d   = skid_pc_q;
                    out_vld_d  = 1'b1;
                    skid_vld_d = 1'b0;
                end else if (w_up_xfer) begin
                    out_inst_d = i_inst;
                    out_pc_d   = i_pc;
                    out_vld_d  = 1'b1;
                end else begin
                    out_vld_d  = 1'b0;
                end
            end else if (w_up_xfer) begin
                // OUT is holding: park the new instruction in SKID.
                skid_inst_d = i_inst;
                skid_pc_d   = i_pc;
                skid_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            out_vld_q   <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            skid_vld_q  <= 1'b0;
            retired_q   <= '0;
        end else begin
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_vld_q   <= out_vld_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_vld_q  <= skid_vld_d;
            retired_q   <= retired_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the presented instruction
    // ------------------------------------------------------------------
    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [FULL_W-1:0]       w_full;
    logic [ADDR_WIDTH-1:0]   w_full_zx;
    logic                    w_is_abs;
    logic                    w_is_rel;
    logic [ADDR_WIDTH-1:0]   w_rel_target;

    assign w_opcode = out_inst_q[WORD_WIDTH-1 -: OPCODE_WIDTH];
    assign w_full   = out_inst_q[FULL_W-1:0];
    assign w_is_abs = (w_opcode == JMP_OPCODE);

    generate
        if (FULL_W >= ADDR_WIDTH) begin : g_abs_trunc
            assign w_full_zx = w_full[ADDR_WIDTH-1:0];
        end else begin : g_abs_zext
            assign w_full_zx = {{(ADDR_WIDTH-FULL_W){1'b0}}, w_full};
        end
    endgenerate

`ifdef DECODE_REL_JMP_EN
    logic [ADDR_WIDTH-1:0] w_full_sx;

    generate
        if (FULL_W >= ADDR_WIDTH) begin : g_rel_trunc
            assign w_full_sx = w_full[ADDR_WIDTH-1:0];
        end else begin : g_rel_sext
            assign w_full_sx = {{(ADDR_WIDTH-FULL_W){w_full[FULL_W-1]}}, w_full};
        end
    endgenerate

    assign w_is_rel     = (w_opcode == REL_JMP_OPCODE);
    assign w_rel_target = out_pc_q + w_full_sx;
`else
    // Relative jumps disabled: the opcode decodes as an ordinary instruction.
    logic w_unused_rel;

    assign w_unused_rel = ^REL_JMP_OPCODE;
    assign w_is_rel     = 1'b0;
    assign w_rel_target = '0;
`endif

    // Every decoded field reads zero while nothing valid is presented.
    assign o_valid        = out_vld_q;
    assign o_opcode       = out_vld_q ? w_opcode : '0;
    assign o_operand_full = out_vld_q ? w_full : '0;
    assign o_operand1     = out_vld_q ? w_full[FULL_W-1 -: OP_W] : '0;
    assign o_operand2     = out_vld_q ? w_full[OP_W-1:0] : '0;
    assign o_pc           = out_vld_q ? out_pc_q : '0;
    assign o_is_jmp       = out_vld_q && (w_is_abs || w_is_rel);
    assign o_next_pc      = !out_vld_q ? '0 :
                            w_is_abs   ? w_full_zx :
                            w_is_rel   ? w_rel_target : '0;
    assign o_retired      = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_pipe
// Purpose  : Self-checking bench for decode_pipe (CNT_WIDTH = 4 so counter
//            wrap is reachable). A vector table covers field decode; hand
//            sequences cover back-pressure, skid, flush, async reset and wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] inst;
    logic [11:0] pc;
    logic        out_valid;
    logic        dn_ready;
    logic [3:0]  opcode;
    logic [11:0] op_full;
    logic [5:0]  op1;
    logic [5:0]  op2;
    logic [11:0] out_pc;
    logic        is_jmp;
    logic [11:0] next_pc;
    logic [3:0]  retired;

    int total = 0;
    int bad   = 0;

    decode_pipe #(
        .ADDR_WIDTH     (12),
        .WORD_WIDTH     (16),
        .OPCODE_WIDTH   (4),
        .JMP_OPCODE     (4'h9),
        .REL_JMP_OPCODE (4'hA),
        .CNT_WIDTH      (4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_flush        (flush),
        .i_valid        (in_valid),
        .o_ready        (out_ready),
        .i_inst         (inst),
        .i_pc           (pc),
        .o_valid        (out_valid),
        .i_ready        (dn_ready),
        .o_opcode       (opcode),
        .o_operand_full (op_full),
        .o_operand1     (op1),
        .o_operand2     (op2),
        .o_pc           (out_pc),
        .o_is_jmp       (is_jmp),
        .o_next_pc      (next_pc),
        .o_retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] inst;
        logic [11:0] pc;
        logic [3:0]  opc;
        logic [5:0]  op1;
        logic [5:0]  op2;
        logic [11:0] full;
        logic        jmp;
        logic [11:0] npc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ins, input logic [11:0] p);
        in_valid = 1'b1;
        inst     = ins;
        pc       = p;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic        rel_jmp;
    logic [11:0] rel_npc;

    initial begin
`ifdef DECODE_REL_JMP_EN
        rel_jmp = 1'b1;
        rel_npc = 12'h008;
`else
        rel_jmp = 1'b0;
        rel_npc = 12'h000;
`endif
        vecs[0] = '{16'h9123, 12'h005, 4'h9, 6'h04, 6'h23, 12'h123, 1'b1, 12'h123};
        vecs[1] = '{16'h1001, 12'h010, 4'h1, 6'h00, 6'h01, 12'h001, 1'b0, 12'h000};
        vecs[2] = '{16'h9FFF, 12'h007, 4'h9, 6'h3F, 6'h3F, 12'hFFF, 1'b1, 12'hFFF};
        vecs[3] = '{16'hAFFE, 12'h00A, 4'hA, 6'h3F, 6'h3E, 12'hFFE, rel_jmp, rel_npc};
        vecs[4] = '{16'h0000, 12'hFFF, 4'h0, 6'h00, 6'h00, 12'h000, 1'b0, 12'h000};
        vecs[5] = '{16'h9800, 12'h001, 4'h9, 6'h20, 6'h00, 12'h800, 1'b1, 12'h800};
        vecs[6] = '{16'h8ABC, 12'h123, 4'h8, 6'h2A, 6'h3C, 12'hABC, 1'b0, 12'h000};

        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        dn_ready = 1'b1;
        inst     = '0;
        pc       = '0;

        // Reset state (asynchronous: visible before any clock edge)
        #2;
        check("rst_valid",   out_valid, 0);
        check("rst_ready",   out_ready, 1);
        check("rst_retired", retired,   0);
        check("rst_opcode",  opcode,    0);
        check("rst_is_jmp",  is_jmp,    0);
        check("rst_next_pc", next_pc,   0);
        step();
        rst = 1'b0;

        // Table: back-to-back stream with i_ready=1, one-cycle latency
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            inst     = vecs[i].inst;
            pc       = vecs[i].pc;
            step();
            check($sformatf("v%0d_valid", i),  out_valid, 1);
            check($sformatf("v%0d_opcode", i), opcode,    vecs[i].opc);
            check($sformatf("v%0d_op1", i),    op1,       vecs[i].op1);
            check($sformatf("v%0d_op2", i),    op2,       vecs[i].op2);
            check($sformatf("v%0d_full", i),   op_full,   vecs[i].full);
            check($sformatf("v%0d_pc", i),     out_pc,    vecs[i].pc);
            check($sformatf("v%0d_is_jmp", i), is_jmp,    vecs[i].jmp);
            if (vecs[i].jmp)
                check($sformatf("v%0d_next_pc", i), next_pc, vecs[i].npc);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid",   out_valid, 0);
        check("drain_opcode",  opcode,    0);
        check("drain_full",    op_full,   0);
        check("drain_pc",      out_pc,    0);
        check("drain_retired", retired,   7);

        // Back-pressure: second instruction lands in SKID, outputs stable
        do_reset();
        dn_ready = 1'b0;
        send(16'h1001, 12'h020);
        check("bp_first_valid", out_valid, 1);
        check("bp_first_ready", out_ready, 1);
        send(16'h2002, 12'h021);
        check("bp_skid_ready",  out_ready, 0);
        check("bp_hold_opcode", opcode,    1);
        step();
        check("bp_stable_opcode", opcode,  1);
        check("bp_stable_full",   op_full, 12'h001);
        check("bp_stable_pc",     out_pc,  12'h020);
        dn_ready = 1'b1;
        step();
        check("bp_second_opcode", opcode,    2);
        check("bp_second_pc",     out_pc,    12'h021);
        check("bp_second_ready",  out_ready, 1);
        check("bp_retired1",      retired,   1);
        step();
        check("bp_empty_valid",   out_valid, 0);
        check("bp_retired2",      retired,   2);

        // Flush with SKID full and a simultaneous upstream offer
        do_reset();
        dn_ready = 1'b0;
        send(16'h1001, 12'h030);
        send(16'h2002, 12'h031);
        flush    = 1'b1;
        in_valid = 1'b1;
        inst     = 16'h3003;
        pc       = 12'h032;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid",   out_valid, 0);
        check("fl_ready",   out_ready, 1);
        check("fl_retired", retired,   0);
        dn_ready = 1'b1;
        step();
        check("fl_no_ghost1", out_valid, 0);
        step();
        check("fl_no_ghost2", out_valid, 0);
        check("fl_retired2",  retired,   0);

        // Async reset with OUT and SKID full, retired nonzero
        send(16'h5005, 12'h040);
        step();
        check("ar_pre_retired", retired, 1);
        dn_ready = 1'b0;
        send(16'h6006, 12'h041);
        send(16'h7007, 12'h042);
        check("ar_full_ready", out_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid",   out_valid, 0);
        check("ar_ready",   out_ready, 1);
        check("ar_retired", retired,   0);
        step();
        rst      = 1'b0;
        dn_ready = 1'b1;
        send(16'h9123, 12'h005);
        check("ar_post_valid",   out_valid, 1);
        check("ar_post_opcode",  opcode,    9);
        check("ar_post_next_pc", next_pc,   12'h123);
        step();
        check("ar_post_retired", retired, 1);

        // Counter wrap: 17 transfers on a 4-bit counter
        do_reset();
        dn_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            inst     = 16'h1000 + 16'(i);
            pc       = 12'(i);
            step();
            check($sformatf("wrap_order%0d", i), op_full, 12'(i));
        end
        in_valid = 1'b0;
        step();
        check("wrap_retired", retired,   1);
        check("wrap_valid",   out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
